key_scan_ctrl: RTL

KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

---
 rtl/key_scan_ctrl_pkg.sv | 17 +
 rtl/key_prio_enc.sv | 24 ++
 rtl/key_scan_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/key_scan_ctrl_pkg.sv
// Shared definitions for the key scanner.
//   KeyCodeW / key_code_t : width and type of an encoded key number (0..15)
//   NumKeys               : number of raw key lines
//   St*                   : 2-bit debounce FSM state encoding
package key_scan_ctrl_pkg;

    localparam int unsigned KeyCodeW = 4;
    localparam int unsigned NumKeys  = 16;

    typedef logic [KeyCodeW-1:0] key_code_t;

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StDbPress   = 2'd1;
    localparam logic [1:0] StHeld      = 2'd2;
    localparam logic [1:0] StDbRelease = 2'd3;

endpackage

// File: rtl/key_prio_enc.sv
// Combinational priority encoder for active-low key lines.
//   keys_n_i      : key lines, 0 = pressed
//   any_pressed_o : 1 when any line is low
//   code_o        : highest pressed index i reported as code 15-i (0 when none pressed)
module key_prio_enc
    import key_scan_ctrl_pkg::*;
(
    input  logic [NumKeys-1:0] keys_n_i,
    output logic               any_pressed_o,
    output key_code_t          code_o
);

    always_comb begin
        any_pressed_o = ~(&keys_n_i);
        code_o        = '0;
        // Ascending scan: the last hit, i.e. the highest index, wins.
        for (int i = 0; i < NumKeys; i++) begin
            if (!keys_n_i[i]) begin
                code_o = KeyCodeW'(NumKeys - 1 - i);
            end
        end
    end

endmodule

// File: rtl/key_scan_ctrl.sv
// Debounced 16-key scanner with a small event FIFO.
//   clock, reset_n : clock and asynchronous active-low reset
//   keys           : raw active-low key lines, asynchronous to clock
//   key_ack        : pop the head event while key_valid is 1
//   key_valid      : FIFO non-empty
//   key_code       : head-of-FIFO key code
//   key_held       : a debounced key is currently down (HELD / DB_RELEASE)
//   overflow       : sticky, a debounced press was dropped on a full FIFO
module key_scan_ctrl
    import key_scan_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NumKeys-1:0]  keys,
    input  logic                key_ack,
    output logic                key_valid,
    output logic [KeyCodeW-1:0] key_code,
    output logic                key_held,
    output logic                overflow
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [15:0] DbCnt = 16'(DB_CYCLES);
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    // Two-flop synchronizer; idle value is all-ones (nothing pressed).
    logic [NumKeys-1:0] sync1_q, sync2_q;

    logic      any_pressed;
    key_code_t enc_code;

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    key_code_t   cap_q, cap_d;
    logic        push;

    key_code_t       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            full, pop, do_push, drop;

    key_prio_enc u_prio_enc (
        .keys_n_i      (sync2_q),
        .any_pressed_o (any_pressed),
        .code_o        (enc_code)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_pressed) begin
                    state_d = StDbPress;
                    cap_d   = enc_code;
                    cnt_d   = 16'd1;
                end
            end
            StDbPress: begin
                if (any_pressed && (enc_code == cap_q)) begin
                    if (cnt_q == DbCnt) begin
                        push    = 1'b1;
                        state_d = StHeld;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    // Glitch or key change: drop the candidate silently.
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StHeld: begin
                // Presses of other keys are ignored here (no rollover).
                if (!any_pressed) begin
                    state_d = StDbRelease;
                    cnt_d   = 16'd1;
                end
            end
            StDbRelease: begin
                if (any_pressed) begin
                    state_d = StHeld;
                end else if (cnt_q == DbCnt) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        full    = (count_q == FullCnt);
        pop     = key_ack && key_valid;
        // When full, a same-cycle pop frees the slot the write lands in.
        do_push = push && (!full || pop);
        drop    = push && full && !pop;
        count_d = count_q + CntW'(do_push) - CntW'(pop);
        if (drop) begin
            overflow_d = 1'b1;
        end else if (pop) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            state_q    <= StIdle;
            cnt_q      <= '0;
            cap_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= keys;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Storage needs no reset: it is only observed while count_q is non-zero.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= cap_q;
        end
    end

    assign key_valid = (count_q != '0);
    assign key_code  = key_valid ? mem_q[rd_ptr_q] : '0;
    assign key_held  = (state_q == StHeld) || (state_q == StDbRelease);
    assign overflow  = overflow_q;

endmodule
